// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared types and constants for the iterative multiply/divide unit.
//            MULTDIV_BOOTH4_EN selects the radix-4 Booth multiply iteration count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

  localparam int WIDTH = 32;
`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_ITERS = 16;
`else
  localparam int MULT_ITERS = 32;
`endif
  localparam int DIV_ITERS = 32;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // INT_MIN maps to 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_counter.sv
// ============================================================================
// Module   : multdiv_counter
// Brief    : 6-bit iteration counter with clear, enable and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [5:0] i_last,
  output logic       o_terminal
);

  logic [5:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 6'd1;
    end
  end

  assign o_terminal = (r_count == i_last);

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module   : multdiv_unit
// Brief    : Iterative signed 32-bit multiply / restoring divide on magnitudes.
//            Define MULTDIV_BOOTH4_EN for a radix-4 Booth multiply (16 iterations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  import multdiv_pkg::*;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_start;
  logic               w_terminal;
  logic [5:0]         w_last;
  logic               r_op_mult;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_operand;
  logic [2*WIDTH-1:0] r_acc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = r_op_mult ? 6'(MULT_ITERS - 1) : 6'(DIV_ITERS - 1);

  multdiv_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_start),
    .i_enable   ((r_state == RUN) && !w_start),
    .i_last     (w_last),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        RUN:     w_state_next = w_terminal ? DONE : RUN;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Shared 33-bit adder: add for shift-add multiply, subtract for divide.
  logic [WIDTH:0] w_add_a;
  logic [WIDTH:0] w_add_b;
  logic [WIDTH:0] w_sum;

  assign w_add_a = r_op_mult ? {1'b0, r_acc[2*WIDTH-1:WIDTH]} : {1'b0, r_acc[2*WIDTH-2:WIDTH-1]};
  assign w_add_b = {1'b0, r_operand};
  assign w_sum   = r_op_mult ? (w_add_a + w_add_b) : (w_add_a - w_add_b);

  logic [2*WIDTH-1:0] w_div_step;
  assign w_div_step = w_sum[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                   : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

`ifdef MULTDIV_BOOTH4_EN
  logic [1:0]       r_acc_ext;
  logic             r_booth_prev;
  logic [WIDTH+1:0] w_hi_ext;
  logic [WIDTH+1:0] w_pp;
  logic [WIDTH+1:0] w_booth_sum;

  assign w_hi_ext = {r_acc_ext, r_acc[2*WIDTH-1:WIDTH]};

  // Booth digit from multiplier bits {b1, b0, b-1}; multiplicand is a magnitude.
  always_comb begin
    w_pp = '0;
    case ({r_acc[1:0], r_booth_prev})
      3'b001, 3'b010: w_pp = {2'b00, r_operand};
      3'b011:         w_pp = {1'b0, r_operand, 1'b0};
      3'b100:         w_pp = ~{1'b0, r_operand, 1'b0} + (WIDTH+2)'(1);
      3'b101, 3'b110: w_pp = ~{2'b00, r_operand} + (WIDTH+2)'(1);
      default:        w_pp = '0;
    endcase
  end

  assign w_booth_sum = w_hi_ext + w_pp;
`else
  logic [2*WIDTH-1:0] w_mult_step;
  assign w_mult_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
`endif

  // Sign fixup: Booth multiplies the signed multiplier directly.
  logic               w_neg;
  logic [2*WIDTH-1:0] w_fix;
  logic [WIDTH:0]     w_top;
  logic [WIDTH-1:0]   w_final_result;
  logic               w_final_exc;

`ifdef MULTDIV_BOOTH4_EN
  assign w_neg = r_op_mult ? r_sign_a : (r_sign_a ^ r_sign_b);
`else
  assign w_neg = r_sign_a ^ r_sign_b;
`endif
  assign w_fix = w_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
  assign w_top = w_fix[2*WIDTH-1:WIDTH-1];

  always_comb begin
    w_final_result = w_fix[WIDTH-1:0];
    w_final_exc    = 1'b0;
    if (r_op_mult) begin
      w_final_exc = ~((&w_top) | ~(|w_top));
    end else if (r_operand == '0) begin
      w_final_result = '0;
      w_final_exc    = 1'b1;
    end else begin
      // A positive quotient of magnitude 2^31 only arises from INT_MIN / -1.
      w_final_exc = ~w_neg & r_acc[WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op_mult      <= 1'b0;
      r_sign_a       <= 1'b0;
      r_sign_b       <= 1'b0;
      r_operand      <= '0;
      r_acc          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      r_acc_ext      <= '0;
      r_booth_prev   <= 1'b0;
`endif
    end else begin
      data_resultRDY <= (r_state == DONE);
      if (r_state == DONE) begin
        data_result    <= w_final_result;
        data_exception <= w_final_exc;
      end
      if (w_start) begin
        r_op_mult <= ctrl_MULT;
        r_sign_a  <= data_operandA[WIDTH-1];
        r_sign_b  <= data_operandB[WIDTH-1];
        r_operand <= ctrl_MULT ? magnitude(data_operandA) : magnitude(data_operandB);
`ifdef MULTDIV_BOOTH4_EN
        r_acc        <= {{WIDTH{1'b0}}, ctrl_MULT ? data_operandB : magnitude(data_operandA)};
        r_acc_ext    <= '0;
        r_booth_prev <= 1'b0;
`else
        r_acc <= {{WIDTH{1'b0}}, ctrl_MULT ? magnitude(data_operandB) : magnitude(data_operandA)};
`endif
      end else if (r_state == RUN) begin
`ifdef MULTDIV_BOOTH4_EN
        if (r_op_mult) begin
          {r_acc_ext, r_acc} <= {w_booth_sum[WIDTH+1], w_booth_sum[WIDTH+1], w_booth_sum,
                                 r_acc[WIDTH-1:2]};
          r_booth_prev       <= r_acc[1];
        end else begin
          r_acc <= w_div_step;
        end
`else
        r_acc <= r_op_mult ? w_mult_step : w_div_step;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module   : tb_multdiv_unit
// Brief    : Self-checking bench for multdiv_unit: vector table, corner
//            sequences and randomized operations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_LAT = 17;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock;
  logic        reset_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int tests = 0;
  int fails = 0;
  int rdy_count = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset_n),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (data_resultRDY) rdy_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          op_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    bit          exp_exc;
  } vec_t;

  vec_t vecs[16];

  // {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model(bit m, logic [31:0] a, logic [31:0] b);
    longint p;
    int     q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_mult = m;
    ctrl_div  = d;
    op_a      = a;
    op_b      = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
  endtask

  task automatic wait_ready(output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat       = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_exc, input int exp_lat);
    int lat;
    bit to;
    start_op(m, d, a, b);
    wait_ready(lat, to);
    if (to) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no ready within 200 cycles, expected %0d", name, exp_lat);
    end else begin
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, data_result, exp_res);
      check({name, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
      @(posedge clock);
      #1;
      check({name, " ready width"}, {31'd0, data_resultRDY}, 32'd0);
    end
  endtask

  initial begin
    int          lat;
    bit          to;
    int          n0;
    logic [32:0] exp;
    logic [31:0] specials[5];
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rm;

    vecs[0]  = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b1, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[4]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[6]  = '{1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 1'b0};
    vecs[8]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[9]  = '{1'b0, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 32'h0000000A, 32'h00000003, 32'h00000003, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[12] = '{1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[13] = '{1'b0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[14] = '{1'b0, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{1'b0, 32'h00000003, 32'h00000007, 32'h00000000, 1'b0};

    specials[0] = 32'h00000000;
    specials[1] = 32'h00000001;
    specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000;
    specials[4] = 32'h7FFFFFFF;

    reset_n   = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #2;
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset ready", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op_mult, !vecs[i].op_mult, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_exc, vecs[i].op_mult ? MULT_LAT : DIV_LAT);
    end

    // Restart: a DIV issued mid-multiply replaces it with one ready pulse.
    n0 = rdy_count;
    start_op(1'b1, 1'b0, 32'd6, 32'd6);
    repeat (9) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd9, 32'd3);
    wait_ready(lat, to);
    if (to) begin
      tests++;
      fails++;
      $display("FAIL restart timeout: no ready within 200 cycles, expected %0d", DIV_LAT);
    end else begin
      check("restart latency", 32'(lat), 32'(DIV_LAT));
      check("restart result", data_result, 32'd3);
    end
    repeat (40) @(posedge clock);
    check("restart pulse count", 32'(rdy_count - n0), 32'd1);

    run_op("simultaneous", 1'b1, 1'b1, 32'd12, 32'd4, 32'd48, 1'b0, MULT_LAT);
    run_op("pre-reset", 1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, MULT_LAT);

    // Reset mid-divide: outputs clear at once, no ready pulse follows.
    start_op(1'b0, 1'b1, 32'd100, 32'd10);
    repeat (19) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    check("midreset ready", {31'd0, data_resultRDY}, 32'd0);
    n0 = rdy_count;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    check("midreset pulse count", 32'(rdy_count - n0), 32'd0);
    run_op("post-reset", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, MULT_LAT);

    for (int i = 0; i < 150; i++) begin
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'($urandom_range(0, 200)) - 32'd100;
        2:       ra = specials[$urandom_range(0, 4)];
        default: ra = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 200)) - 32'd100;
        2:       rb = specials[$urandom_range(0, 4)];
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      exp = model(rm, ra, rb);
      run_op($sformatf("rand%0d %s %h %h", i, rm ? "mul" : "div", ra, rb), rm, !rm, ra, rb,
             exp[31:0], exp[32], rm ? MULT_LAT : DIV_LAT);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
